// File: rtl/mips_io_port_if.sv
// mips_io_port_if: core load/store bus plus the PortOut valid/ready stream.
// The master side is the core and the external consumer; the slave side is the port.
interface mips_io_port_if;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Hit;
    logic [31:0] PortOut;
    logic        PortOutValid;
    logic        PortOutReady;

    modport master (
        output MemWrite, MemRead, Address, WriteData, PortOutReady,
        input  ReadData, Hit, PortOut, PortOutValid
    );

    modport slave (
        input  MemWrite, MemRead, Address, WriteData, PortOutReady,
        output ReadData, Hit, PortOut, PortOutValid
    );
endinterface

// File: rtl/mips_io_port.sv
// mips_io_port: memory-mapped I/O port with a synchronized input register and an output FIFO.
// Define IO_DROP_COUNT_EN to count pushes dropped on a full FIFO (status bits [15:8]).
module mips_io_port #(
    parameter logic [31:0] OUT_ADDR    = 32'h1001_0024,
    parameter logic [31:0] IN_ADDR     = 32'h1001_0028,
    parameter logic [31:0] STATUS_ADDR = 32'h1001_002C,
    parameter int          FIFO_DEPTH  = 4
) (
    input logic           clk,
    input logic           reset,
    mips_io_port_if.slave bus,
    input logic [7:0]     PortIn,
    input logic           PortInStrobe
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    // Word compare that still consumes every address bit.
    function automatic logic match(input logic [31:0] a, input logic [31:0] b);
        return ((a ^ b) & ~32'h3) == 32'h0;
    endfunction

    logic [7:0]    in_s1, in_s2, in_data, drop_field;
    logic          stb_s1, stb_s2, stb_s3, in_pending, overrun;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [31:0]   head_next, status, port_out;
    logic [AW-1:0] rd_ptr, wr_ptr, rd_next;
    logic [AW:0]   count, count_next;
    logic          hit_out, hit_in, hit_status, rd_in, rd_status, stb_edge;
    logic          empty, full, push, pop, push_ok;

    always_comb begin
        hit_out      = match(bus.Address, OUT_ADDR);
        hit_in       = match(bus.Address, IN_ADDR);
        hit_status   = match(bus.Address, STATUS_ADDR);
        rd_in        = bus.MemRead && hit_in;
        rd_status    = bus.MemRead && hit_status;
        stb_edge     = stb_s2 && !stb_s3;
        empty        = count == '0;
        full         = count == FULL;
        pop          = !empty && bus.PortOutReady;
        push         = bus.MemWrite && hit_out;
        push_ok      = push && (!full || pop);
        rd_next      = pop ? rd_ptr + 1'b1 : rd_ptr;
        count_next   = count + (AW + 1)'(push_ok) - (AW + 1)'(pop);
        // A push landing in the slot that becomes the head bypasses the array.
        head_next    = (push_ok && rd_next == wr_ptr) ? bus.WriteData : mem[rd_next];
        status       = {16'h0, drop_field, 3'b0, empty, overrun, full, !empty, in_pending};
        bus.Hit      = hit_out || hit_in || hit_status;
        bus.ReadData = !bus.MemRead ? 32'h0 : hit_in ? {24'h0, in_data} : hit_status ? status : 32'h0;
        bus.PortOutValid = !empty;
        bus.PortOut  = port_out;
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            in_s1      <= '0;
            in_s2      <= '0;
            stb_s1     <= 1'b0;
            stb_s2     <= 1'b0;
            stb_s3     <= 1'b0;
            in_data    <= '0;
            in_pending <= 1'b0;
            overrun    <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            port_out   <= '0;
        end else begin
            in_s1      <= PortIn;
            in_s2      <= in_s1;
            stb_s1     <= PortInStrobe;
            stb_s2     <= stb_s1;
            stb_s3     <= stb_s2;
            if (stb_edge)
                in_data <= in_s2;
            // A new strobe edge wins over a same-cycle read clear.
            in_pending <= stb_edge || (in_pending && !rd_in);
            overrun    <= (stb_edge && in_pending) || (overrun && !rd_status);
            rd_ptr     <= rd_next;
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            count      <= count_next;
            if (count_next != '0)
                port_out <= head_next;
        end

    always_ff @(posedge clk)
        if (push_ok)
            mem[wr_ptr] <= bus.WriteData;

`ifdef IO_DROP_COUNT_EN
    logic [7:0] drop_cnt;
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            drop_cnt <= '0;
        else if (rd_status)
            drop_cnt <= '0;
        else if (push && !push_ok && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
    assign drop_field = drop_cnt;
`else
    assign drop_field = 8'h0;
`endif

    a_count_bound: assert property (@(posedge clk) disable iff (!reset) count <= FULL);
endmodule

// File: tb/tb_mips_io_port.sv
// tb_mips_io_port: randomized scoreboard bench for mips_io_port.
// A driver advances a behavioural model per clock; a negedge monitor compares against queued expectations.
module tb_mips_io_port;
    localparam logic [31:0] OUT_A = 32'h1001_0024;
    localparam logic [31:0] IN_A  = 32'h1001_0028;
    localparam logic [31:0] ST_A  = 32'h1001_002C;
    localparam int D = 4;

    typedef struct {
        logic [31:0] rd;
        logic        hit;
    } bus_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] PortIn = 8'h0;
    logic       PortInStrobe = 1'b0;

    mips_io_port_if bus ();

    mips_io_port #(.FIFO_DEPTH(D)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave),
        .PortIn(PortIn),
        .PortInStrobe(PortInStrobe)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc = 0, mcount = 0, m_drop = 0, stb_cnt = 0;
    bit m_pend = 0, m_ovr = 0, stb_auto = 0;
    logic [7:0]  m_in_data = 8'h0;
    logic [31:0] last_head = 32'h0;
    logic [31:0] exp_q[$];
    bus_t        bus_q[$];
    bus_t        mb;
    int          ev_cyc[$];
    logic [7:0]  ev_dat[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit same(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

    task automatic model_clear();
        mcount = 0; m_drop = 0; m_pend = 0; m_ovr = 0; m_in_data = 8'h0; last_head = 32'h0;
        exp_q.delete(); bus_q.delete(); ev_cyc.delete(); ev_dat.delete();
        PortInStrobe = 1'b0; stb_cnt = 0;
    endtask

    task automatic bus_idle();
        bus.MemWrite = 1'b0; bus.MemRead = 1'b1; bus.Address = ST_A;
        bus.WriteData = 32'h0; bus.PortOutReady = 1'b0;
    endtask

    // New data becomes visible to the core three edges after the strobe rises.
    task automatic raise(input logic [7:0] d);
        PortIn = d;
        PortInStrobe = 1'b1;
        ev_cyc.push_back(cyc + 3);
        ev_dat.push_back(d);
    endtask

    // Called 1 time unit after a rising edge: first account for that edge, then apply new inputs.
    task automatic step(input int op, input logic [31:0] wd, input logic rdy);
        logic [31:0] a;
        bit ev, rdin, rdst, push, pop, acc;
        logic [7:0] evd;
        int st;
        bus_t e;
        cyc++;
        ev = 0; evd = 8'h0;
        if (ev_cyc.size() != 0 && ev_cyc[0] == cyc) begin
            ev = 1; evd = ev_dat.pop_front(); ev_cyc.delete(0);
        end
        rdin = bus.MemRead && same(bus.Address, IN_A);
        rdst = bus.MemRead && same(bus.Address, ST_A);
        push = bus.MemWrite && same(bus.Address, OUT_A);
        pop  = mcount > 0 && bus.PortOutReady;
        acc  = push && (mcount < D || pop);
        if (acc) exp_q.push_back(bus.WriteData);
        m_drop = rdst ? 0 : (push && !acc && m_drop < 255) ? m_drop + 1 : m_drop;
        mcount = mcount + int'(acc) - int'(pop);
        m_ovr  = (ev && m_pend) ? 1'b1 : rdst ? 1'b0 : m_ovr;
        m_pend = ev ? 1'b1 : rdin ? 1'b0 : m_pend;
        if (ev) m_in_data = evd;
        if (stb_auto) begin
            stb_cnt--;
            if (stb_cnt <= 0) begin
                if (PortInStrobe) begin
                    PortInStrobe = 1'b0;
                    stb_cnt = $urandom_range(2, 8);
                end else begin
                    raise(8'($urandom));
                    stb_cnt = $urandom_range(3, 5);
                end
            end
        end
        case (op)
            1, 7:    a = OUT_A;
            2, 4:    a = IN_A;
            3, 5:    a = ST_A;
            6:       a = 32'h1001_0000 | (32'($urandom_range(0, 8)) << 2);
            default: a = OUT_A;
        endcase
        a = a | 32'($urandom_range(0, 3));
        bus.MemWrite = op inside {1, 2, 3};
        bus.MemRead  = op inside {4, 5, 6, 7};
        bus.Address = a;
        bus.WriteData = wd;
        bus.PortOutReady = rdy;
        st = int'(m_pend) + 2 * int'(mcount != 0) + 4 * int'(mcount == D) + 8 * int'(m_ovr) + 16 * int'(mcount == 0);
`ifdef IO_DROP_COUNT_EN
        st += m_drop * 256;
`endif
        e.hit = same(a, OUT_A) || same(a, IN_A) || same(a, ST_A);
        e.rd  = !bus.MemRead ? 32'h0 : same(a, IN_A) ? {24'h0, m_in_data} : same(a, ST_A) ? 32'(st) : 32'h0;
        bus_q.push_back(e);
    endtask

    task automatic tick(input int op, input logic [31:0] wd, input logic rdy);
        @(posedge clk);
        #1;
        step(op, wd, rdy);
    endtask

    always @(negedge clk)
        if (reset) begin
            if (bus_q.size() != 0) begin
                mb = bus_q.pop_front();
                check("ReadData", bus.ReadData, mb.rd);
                check("Hit", 32'(bus.Hit), 32'(mb.hit));
            end
            check("PortOutValid", 32'(bus.PortOutValid), 32'(mcount != 0));
            if (bus.PortOutValid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL PortOut: got %h expected no entry (cycle %0d)", bus.PortOut, cyc);
                end else begin
                    check("PortOut", bus.PortOut, exp_q[0]);
                    if (bus.PortOutReady) last_head = exp_q.pop_front();
                end
            end else
                check("PortOut_hold", bus.PortOut, last_head);
        end

    initial begin
        int rp;
        bus_idle();
        model_clear();
        // Reset held with the strobe toggling: everything stays cleared.
        repeat (6) begin
            @(negedge clk);
            PortInStrobe = ~PortInStrobe;
            #1;
            check("rst_valid", 32'(bus.PortOutValid), 32'h0);
            check("rst_portout", bus.PortOut, 32'h0);
            check("rst_status", bus.ReadData, 32'h10);
        end
        PortInStrobe = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b1;
        repeat (4) tick(5, 0, 0);
        // Single input byte, then read it and recheck status.
        tick(0, 0, 0);
        raise(8'hA5);
        repeat (4) tick(5, 0, 0);
        PortInStrobe = 1'b0;
        tick(4, 0, 0);
        tick(5, 0, 0);
        tick(5, 0, 0);
        // Overrun: two bytes without a read in between.
        raise(8'h11);
        repeat (4) tick(0, 0, 0);
        PortInStrobe = 1'b0;
        repeat (3) tick(0, 0, 0);
        raise(8'h22);
        repeat (4) tick(0, 0, 0);
        PortInStrobe = 1'b0;
        repeat (2) tick(0, 0, 0);
        tick(4, 0, 0);
        tick(5, 0, 0);
        tick(5, 0, 0);
        // Fill past full, then drain; three rounds exercise pointer wrap.
        for (int r = 0; r < 3; r++) begin
            for (int i = 1; i <= 5; i++) tick(1, 32'(i), 1'b0);
            tick(5, 0, 0);
            repeat (6) tick(0, 0, 1);
        end
        // Push and pop in the same cycle while full.
        for (int i = 1; i <= 4; i++) tick(1, 32'(i + 16), 1'b0);
        tick(1, 32'd9, 1'b1);
        tick(5, 0, 0);
        repeat (6) tick(0, 0, 1);
        // Asynchronous reset between edges with entries in flight.
        for (int i = 1; i <= 3; i++) tick(1, 32'(i + 32), 1'b0);
        tick(0, 0, 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.PortOutValid), 32'h0);
        check("midrst_portout", bus.PortOut, 32'h0);
        model_clear();
        bus_idle();
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        tick(5, 0, 0);
        tick(0, 0, 1);
        // Randomized traffic with free-running input strobes.
        stb_auto = 1;
        for (int blk = 0; blk < 15; blk++) begin
            rp = $urandom_range(0, 100);
            for (int i = 0; i < 100; i++)
                tick($urandom_range(0, 7), $urandom, 1'($urandom_range(0, 99) < rp));
        end
        stb_auto = 0;
        PortInStrobe = 1'b0;
        repeat (10) tick(0, 0, 1);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mips_io_port.md
Name: mips_io_port

Overview:
Memory-mapped I/O peripheral that sits directly downstream of the single-cycle MIPS core's data path. It consumes the core's store/load address and data and produces the board-level PortOut, which is buffered through a small output FIFO with a valid/ready handshake. It also samples the external 8-bit PortIn strobe interface through a synchronizer and presents it to the core as readable registers. The core reads it combinationally in the same cycle as the load.

Parameters:
OUT_ADDR, 32'h1001_0024, word address of output data register (write-only, push to FIFO)
IN_ADDR, 32'h1001_0028, word address of input data register (read clears pending)
STATUS_ADDR, 32'h1001_002C, word address of status register (read-only)
FIFO_DEPTH, 4, output FIFO entries; power of two, 2..16

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
MemWrite  input  1  core store strobe, valid for one clk
MemRead  input  1  core load strobe
Address  input  32  core ALU result (byte address)
WriteData  input  32  core store data (rt)
ReadData  output  32  load data, combinational from Address
Hit  output  1  Address matches any of the three registers (word-aligned compare, bits [1:0] ignored)
PortIn  input  8  external input data, asynchronous to clk
PortInStrobe  input  1  external "new data" strobe, asynchronous, ≥3 clk high
PortOut  output  32  FIFO head data
PortOutValid  output  1  FIFO non-empty
PortOutReady  input  1  external consumer accepts head

Behaviour:
- reset low: FIFO empty; PortOut=0; PortOutValid=0; in_data=0; in_pending=0; overrun=0; synchronizers=0. All outputs return to these values immediately, mid-transfer included.
- Input path: PortIn and PortInStrobe each pass through a 2-FF synchronizer. A rising edge on the synchronized strobe (third FF for edge detect) latches the synchronized PortIn into in_data and sets in_pending. Edge to in_pending latency: 3 clk.
- If in_pending is already 1 at a new strobe edge: in_data is overwritten and overrun is set (sticky).
- Load from IN_ADDR with MemRead=1: ReadData={24'b0,in_data}; at the next edge in_pending clears. If a strobe edge occurs in the same cycle, the set wins: in_pending stays 1 and in_data takes the new value.
- Load from STATUS_ADDR: ReadData={27'b0, count==0, overrun, fifo_full, PortOutValid, in_pending}, where bits [4:0] are in_pending, PortOutValid, fifo_full, overrun, fifo_empty. Reading status clears overrun at the next edge.
- ReadData is 0 when Hit=0 or MemRead=0.
- Output FIFO: a store to OUT_ADDR pushes WriteData. The entry is visible at PortOut/PortOutValid on the next cycle, so latency is 1 clk.
- Pop occurs when PortOutValid && PortOutReady at the clk edge.
- FIFO is full when count==FIFO_DEPTH. A push while full is dropped, with data and count unchanged.
- Simultaneous push and pop:
  - when full: both are accepted and count is unchanged.
  - when empty: the push is accepted and the pop is ignored, since valid was 0.
- Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.
- PortOut holds the head entry. It holds its last value when empty, and is 0 only after reset.
- Stores to IN_ADDR or STATUS_ADDR are ignored.
- Misaligned addresses (Address[1:0]≠0) still decode on the word address.

Optional Feature:
IO_DROP_COUNT_EN
- Defined: an 8-bit saturating counter increments on every push dropped due to FIFO full. It is reported in status bits [15:8]. It clears on reset and on a status read, at the next edge.
- Not defined: bits [15:8] read 0 and no counter logic is generated.

Test Plan:
1. Reset: hold reset=0 with PortInStrobe toggling -> PortOutValid=0, PortOut=0, status read = 32'h0000_0010. After release, status still 32'h10 until the first strobe.
2. Input: PortIn=8'hA5, strobe high 4 clk -> status bit0=1 three clk after the strobe rise. Load IN_ADDR -> ReadData=32'h0000_00A5; next status read = 32'h10.
3. Overrun: strobe with 8'h11 then with 8'h22, no read in between -> IN read = 32'h22, status bit3=1. A second status read shows bit3=0.
4. FIFO fill/wrap: PortOutReady=0, store 1,2,3,4,5 to OUT_ADDR -> status bit2=1, PortOut=1, the 5th store is dropped (drop count=1 with IO_DROP_COUNT_EN). Then set PortOutReady=1 -> PortOut sequence is 1,2,3,4 on consecutive clk, then PortOutValid=0. Repeat 3 rounds to check pointer wrap.
5. Simultaneous push/pop when full: FIFO holds 4 entries, Ready=1, store 9 in the same cycle -> count stays 4, last entry popped is 9.
6. Reset mid-transfer: FIFO holds 3 entries, drive reset=0 asynchronously between edges -> PortOutValid and PortOut go to 0 immediately; after release the FIFO is empty.
